// File: rtl/reg_status_file_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_status_file_if
//  Purpose  : Issue/read/snoop bundle between the Tomasulo issue stage, the
//             common data bus and reg_status_file.
//  Signals  : cdb           {valid, tag, data} broadcast from the CDB
//             rs1_addr/rs2_addr      source register indices
//             rs1_value/rs1_q, rs2_value/rs2_q  operand value / producer tag
//             issue_en/issue_rd/issue_tag       destination claim
//             flush         clear every pending tag
//             pending_count registers currently waiting on a producer
//  Modports : master (issue side), slave (register status file)
//  Revision : 1.0  initial release
// ============================================================================
interface reg_status_file_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 8,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 6
);
    logic [DATA_W+TAG_W:0] cdb;
    logic [ADDR_W-1:0]     rs1_addr;
    logic [DATA_W-1:0]     rs1_value;
    logic [TAG_W-1:0]      rs1_q;
    logic [ADDR_W-1:0]     rs2_addr;
    logic [DATA_W-1:0]     rs2_value;
    logic [TAG_W-1:0]      rs2_q;
    logic                  issue_en;
    logic [ADDR_W-1:0]     issue_rd;
    logic [TAG_W-1:0]      issue_tag;
    logic                  flush;
    logic [CNT_W-1:0]      pending_count;

    modport master (
        output cdb, rs1_addr, rs2_addr, issue_en, issue_rd, issue_tag, flush,
        input  rs1_value, rs1_q, rs2_value, rs2_q, pending_count
    );

    modport slave (
        input  cdb, rs1_addr, rs2_addr, issue_en, issue_rd, issue_tag, flush,
        output rs1_value, rs1_q, rs2_value, rs2_q, pending_count
    );
endinterface
`default_nettype wire

// File: rtl/reg_status_file.sv
`default_nettype none
// ============================================================================
//  Module   : reg_status_file
//  Purpose  : Architectural register file with a per-register producer tag
//             (Qi). Issue reads operands as a value (tag 0) or a pending
//             producer tag and claims its destination; the CDB is snooped
//             every cycle to retire pending registers. Register 0 is zero.
//  Ports    : clk  rising-edge clock
//             rst  asynchronous active-high reset
//             bus  reg_status_file_if.slave (cdb, rs1/rs2 reads, issue
//                  claim, flush, pending_count)
//  Options  : REG_STATUS_CDB_BYPASS_EN - forward a same-cycle CDB result onto
//             the read ports when it retires the register being read.
//  Revision : 1.0  initial release
// ============================================================================
module reg_status_file #(
    parameter int NREG   = 32,
    parameter int TAG_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    reg_status_file_if.slave  bus
);

    localparam int c_addr_w = $clog2(NREG);
    localparam int c_cnt_w  = $clog2(NREG) + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  r_value [NREG];
    logic [TAG_W-1:0]   r_tag   [NREG];
    logic [c_cnt_w-1:0] r_pending_count;

    // ------------------------------------------------------------------
    // CDB and issue decode
    // ------------------------------------------------------------------
    logic              w_cdb_valid;
    logic [TAG_W-1:0]  w_cdb_tag;
    logic [DATA_W-1:0] w_cdb_data;
    logic              w_cdb_live;
    logic              w_issue_live;

    assign w_cdb_valid = bus.cdb[DATA_W+TAG_W];
    assign w_cdb_tag   = bus.cdb[DATA_W+TAG_W-1:DATA_W];
    assign w_cdb_data  = bus.cdb[DATA_W-1:0];

    // Tag 0 means "no producer": a CDB carrying tag 0 would otherwise match
    // every ready register, so it is dropped here.
    assign w_cdb_live   = w_cdb_valid && (w_cdb_tag != '0);
    assign w_issue_live = bus.issue_en && (bus.issue_tag != '0) && (bus.issue_rd != '0);

    // ------------------------------------------------------------------
    // Per-register next state
    // ------------------------------------------------------------------
    logic [NREG-1:0]   w_hit;
    logic [NREG-1:0]   w_claim;
    logic [DATA_W-1:0] w_value_nxt [NREG];
    logic [TAG_W-1:0]  w_tag_nxt   [NREG];

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign w_hit[r]       = 1'b0;
            assign w_claim[r]     = 1'b0;
            assign w_value_nxt[r] = '0;
            assign w_tag_nxt[r]   = '0;
        end else begin : g_live
            assign w_hit[r]   = w_cdb_live && (r_tag[r] == w_cdb_tag);
            assign w_claim[r] = w_issue_live && (bus.issue_rd == c_addr_w'(r));

            // The CDB value always lands, even under flush or a same-cycle
            // re-claim: the value belongs to the old producer being retired.
            assign w_value_nxt[r] = w_hit[r] ? w_cdb_data : r_value[r];

            // Tag priority: flush, then a new claim, then retirement.
            assign w_tag_nxt[r] = bus.flush  ? '0            :
                                  w_claim[r] ? bus.issue_tag :
                                  w_hit[r]   ? '0            : r_tag[r];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_value[r] <= '0;
                r_tag[r]   <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                r_value[r] <= w_value_nxt[r];
                r_tag[r]   <= w_tag_nxt[r];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending counter
    // ------------------------------------------------------------------
    // A register that retires and is re-claimed in the same cycle stays
    // pending, so it is excluded from the retire count; a claim only adds
    // one when the destination was previously ready.
    logic [c_cnt_w-1:0] w_retire_cnt;
    logic               w_new_claim;

    always_comb begin
        w_retire_cnt = '0;
        for (int r = 0; r < NREG; r++) begin
            w_retire_cnt = w_retire_cnt + c_cnt_w'(w_hit[r] & ~w_claim[r]);
        end
    end

    assign w_new_claim = w_issue_live && (r_tag[bus.issue_rd] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending_count <= '0;
        end else if (bus.flush) begin
            r_pending_count <= '0;
        end else begin
            r_pending_count <= r_pending_count + c_cnt_w'(w_new_claim) - w_retire_cnt;
        end
    end

    assign bus.pending_count = r_pending_count;

    // ------------------------------------------------------------------
    // Combinational read ports (pre-issue state; same-cycle claims unseen)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_rs1_value;
    logic [TAG_W-1:0]  w_rs1_q;
    logic [DATA_W-1:0] w_rs2_value;
    logic [TAG_W-1:0]  w_rs2_q;

    always_comb begin
        w_rs1_value = r_value[bus.rs1_addr];
        w_rs1_q     = r_tag[bus.rs1_addr];
`ifdef REG_STATUS_CDB_BYPASS_EN
        // w_cdb_live implies a nonzero tag, so only pending registers match.
        if (w_cdb_live && (w_rs1_q == w_cdb_tag)) begin
            w_rs1_value = w_cdb_data;
            w_rs1_q     = '0;
        end
`endif
        if (bus.rs1_addr == '0) begin
            w_rs1_value = '0;
            w_rs1_q     = '0;
        end
    end

    always_comb begin
        w_rs2_value = r_value[bus.rs2_addr];
        w_rs2_q     = r_tag[bus.rs2_addr];
`ifdef REG_STATUS_CDB_BYPASS_EN
        if (w_cdb_live && (w_rs2_q == w_cdb_tag)) begin
            w_rs2_value = w_cdb_data;
            w_rs2_q     = '0;
        end
`endif
        if (bus.rs2_addr == '0) begin
            w_rs2_value = '0;
            w_rs2_q     = '0;
        end
    end

    assign bus.rs1_value = w_rs1_value;
    assign bus.rs1_q     = w_rs1_q;
    assign bus.rs2_value = w_rs2_value;
    assign bus.rs2_q     = w_rs2_q;

endmodule
`default_nettype wire
